// File: rtl/intr_pkg.sv
// -----------------------------------------------------------------------------
// intr_pkg
// Shared definitions for the APB interrupt controller:
//   - register address map
//   - VECTOR codes (NMI, external base, internal base, none)
//   - APB slave FSM state enum
//   - first_set(): lowest set bit finder used by the vector priority logic
// -----------------------------------------------------------------------------
package intr_pkg;

   localparam logic [7:0] ADDR_CTRL     = 8'h00;
   localparam logic [7:0] ADDR_MASK_EXT = 8'h01;
   localparam logic [7:0] ADDR_MASK_INT = 8'h02;
   localparam logic [7:0] ADDR_PEND_EXT = 8'h03;
   localparam logic [7:0] ADDR_PEND_INT = 8'h04;
   localparam logic [7:0] ADDR_VECTOR   = 8'h05;
   localparam logic [7:0] ADDR_STATUS   = 8'h06;
   localparam logic [7:0] ADDR_LAST     = ADDR_STATUS;

   localparam logic [7:0] VEC_NMI      = 8'h80;
   localparam logic [7:0] VEC_EXT_BASE = 8'h10;
   localparam logic [7:0] VEC_INT_BASE = 8'h20;
   localparam logic [7:0] VEC_NONE     = 8'h00;

   // ST_SETUP  : setup phase has been sampled (bus is now in its wait cycle)
   // ST_ACCESS : access phase has been sampled, pready=1 this cycle
   // ST_DONE   : transfer finished, behaves like IDLE for the next setup
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_DONE   = 2'd3
   } apb_state_t;

   // Returns {found, index} of the lowest set bit of bits.
   function automatic logic [3:0] first_set(input logic [7:0] bits);
      logic [3:0] res;
      res = 4'b0000;
      for (int i = 7; i >= 0; i--) begin
         if (bits[i]) begin
            res = {1'b1, 3'(i)};
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/intr_edge_det.sv
// -----------------------------------------------------------------------------
// intr_edge_det
// One interrupt source: two-flop synchroniser, rising-edge detector and a
// sticky pending bit with write-1-to-clear. A new edge in the same cycle as a
// clear keeps the bit set so no event is lost.
// Ports:
//   pclk, preset_n : clock, asynchronous active-low reset
//   src            : asynchronous interrupt source level
//   clr            : W1C strobe for this pending bit (one cycle)
//   pend           : pending bit
// -----------------------------------------------------------------------------
module intr_edge_det (
   input  logic pclk,
   input  logic preset_n,
   input  logic src,
   input  logic clr,
   output logic pend
);

   logic sync1_reg;
   logic sync2_reg;
   logic prev_reg;
   logic pend_reg;
   logic rise;

   // prev_reg starts at 0, so a source already high at reset release is
   // always seen as exactly one edge.
   assign rise = sync2_reg & ~prev_reg;

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         sync1_reg <= 1'b0;
         sync2_reg <= 1'b0;
         prev_reg  <= 1'b0;
         pend_reg  <= 1'b0;
      end else begin
         sync1_reg <= src;
         sync2_reg <= sync1_reg;
         prev_reg  <= sync2_reg;
         pend_reg  <= rise | (pend_reg & ~clr);
      end
   end

   assign pend = pend_reg;

endmodule

// File: rtl/intr_apb_slave.sv
// -----------------------------------------------------------------------------
// intr_apb_slave
// APB-attached interrupt controller: 8 external + 8 internal maskable sources
// and one NMI, each with its own edge-capturing pending bit.
// Ports:
//   pclk, preset_n               : clock, asynchronous active-low reset
//   psel, penable, pwrite        : APB control
//   paddr[7:0], pwdata[7:0]      : APB address / write data
//   prdata[7:0], pready, pslverr : APB response (one wait state per transfer)
//   NMI, IRQ[7:0], Int_IRQ[7:0]  : interrupt sources (asynchronous)
//   i_bit                        : CPU global mask for maskable requests
//   I_flag, UI_flag              : maskable / non-maskable request to CPU
// -----------------------------------------------------------------------------
module intr_apb_slave
   import intr_pkg::*;
(
   input  logic       pclk,
   input  logic       preset_n,
   input  logic       psel,
   input  logic       penable,
   input  logic       pwrite,
   input  logic [7:0] paddr,
   input  logic [7:0] pwdata,
   output logic [7:0] prdata,
   output logic       pready,
   output logic       pslverr,
   input  logic       NMI,
   input  logic [7:0] IRQ,
   input  logic [7:0] Int_IRQ,
   input  logic       i_bit,
   output logic       I_flag,
   output logic       UI_flag
);

   apb_state_t state_reg;
   apb_state_t state_next;

   logic       ctrl_en_reg;
   logic [7:0] mask_ext_reg;
   logic [7:0] mask_int_reg;

   logic       pready_reg;
   logic       pready_next;
   logic       pslverr_reg;
   logic       pslverr_next;
   logic [7:0] prdata_reg;
   logic [7:0] prdata_next;

   logic       i_flag_reg;
   logic       i_flag_next;
   logic       ui_flag_reg;

   logic [7:0] pend_ext;
   logic [7:0] pend_int;
   logic       nmi_pend;
   logic [7:0] clr_ext;
   logic [7:0] clr_int;
   logic       clr_nmi;

   logic       acc_ok;
   logic       addr_err;
   logic       wr_commit;
   logic [7:0] rd_mux;
   logic [7:0] vector;
   logic [3:0] ext_hit;
   logic [3:0] int_hit;

   // ---------------------------------------------------------------- sources
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_ext
         intr_edge_det u_ext (
            .pclk     (pclk),
            .preset_n (preset_n),
            .src      (IRQ[gi]),
            .clr      (clr_ext[gi]),
            .pend     (pend_ext[gi])
         );
      end
      for (gi = 0; gi < 8; gi++) begin : g_int
         intr_edge_det u_int (
            .pclk     (pclk),
            .preset_n (preset_n),
            .src      (Int_IRQ[gi]),
            .clr      (clr_int[gi]),
            .pend     (pend_int[gi])
         );
      end
   endgenerate

   intr_edge_det u_nmi (
      .pclk     (pclk),
      .preset_n (preset_n),
      .src      (NMI),
      .clr      (clr_nmi),
      .pend     (nmi_pend)
   );

   // ------------------------------------------------------------ decode
   assign addr_err = (paddr > ADDR_LAST) || (pwrite && (paddr == ADDR_VECTOR));

   // First access-phase sample after setup: respond in the following cycle.
   assign acc_ok = (state_reg == ST_SETUP) && psel && penable;

   // Writes land at the end of the pready cycle, exactly once.
   assign wr_commit = pready_reg && psel && penable && pwrite && !addr_err;

   assign clr_ext = (wr_commit && (paddr == ADDR_PEND_EXT)) ? pwdata : 8'h00;
   assign clr_int = (wr_commit && (paddr == ADDR_PEND_INT)) ? pwdata : 8'h00;
   assign clr_nmi = wr_commit && (paddr == ADDR_STATUS) && pwdata[0];

   // ------------------------------------------------------------ vector
   always_comb begin
      ext_hit = first_set(pend_ext & mask_ext_reg);
      int_hit = first_set(pend_int & mask_int_reg);
      vector  = VEC_NONE;
      if (nmi_pend) begin
         vector = VEC_NMI;
      end else if (ext_hit[3]) begin
         vector = VEC_EXT_BASE + {5'b00000, ext_hit[2:0]};
      end else if (int_hit[3]) begin
         vector = VEC_INT_BASE + {5'b00000, int_hit[2:0]};
      end
   end

   // ------------------------------------------------------------ read mux
   always_comb begin
      rd_mux = 8'h00;
      case (paddr)
         ADDR_CTRL:     rd_mux = {7'b0000000, ctrl_en_reg};
         ADDR_MASK_EXT: rd_mux = mask_ext_reg;
         ADDR_MASK_INT: rd_mux = mask_int_reg;
         ADDR_PEND_EXT: rd_mux = pend_ext;
         ADDR_PEND_INT: rd_mux = pend_int;
         ADDR_VECTOR:   rd_mux = vector;
         ADDR_STATUS:   rd_mux = {5'b00000, ui_flag_reg, i_flag_reg, nmi_pend};
         default:       rd_mux = 8'h00;
      endcase
   end

   // ------------------------------------------------------------ FSM
   always_comb begin
      state_next   = state_reg;
      pready_next  = 1'b0;
      pslverr_next = 1'b0;
      prdata_next  = 8'h00;

      case (state_reg)
         ST_IDLE, ST_DONE: begin
            if (psel && !penable) begin
               state_next = ST_SETUP;
            end else begin
               state_next = ST_IDLE;
            end
         end
         ST_SETUP: begin
            if (!psel) begin
               state_next = ST_IDLE;
            end else if (penable) begin
               state_next = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            // psel dropping here aborts; wr_commit is gated the same way.
            if (psel && penable) begin
               state_next = ST_DONE;
            end else begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase

      if (acc_ok) begin
         pready_next  = 1'b1;
         pslverr_next = addr_err;
         if (!pwrite && !addr_err) begin
            prdata_next = rd_mux;
         end
      end
   end

   assign i_flag_next = ctrl_en_reg & ~i_bit &
                        (|((pend_ext & mask_ext_reg) | (pend_int & mask_int_reg)));

   // ------------------------------------------------------------ registers
   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         state_reg    <= ST_IDLE;
         pready_reg   <= 1'b0;
         pslverr_reg  <= 1'b0;
         prdata_reg   <= 8'h00;
         ctrl_en_reg  <= 1'b0;
         mask_ext_reg <= 8'h00;
         mask_int_reg <= 8'h00;
         i_flag_reg   <= 1'b0;
         ui_flag_reg  <= 1'b0;
      end else begin
         state_reg   <= state_next;
         pready_reg  <= pready_next;
         pslverr_reg <= pslverr_next;
         prdata_reg  <= prdata_next;
         i_flag_reg  <= i_flag_next;
         ui_flag_reg <= nmi_pend;
         if (wr_commit) begin
            case (paddr)
               ADDR_CTRL:     ctrl_en_reg  <= pwdata[0];
               ADDR_MASK_EXT: mask_ext_reg <= pwdata;
               ADDR_MASK_INT: mask_int_reg <= pwdata;
               default:       ;
            endcase
         end
      end
   end

   assign pready  = pready_reg;
   assign pslverr = pslverr_reg;
   assign prdata  = prdata_reg;
   assign I_flag  = i_flag_reg;
   assign UI_flag = ui_flag_reg;

endmodule

// File: tb/tb_intr_apb_slave.sv
`timescale 1ns/1ps
module tb_intr_apb_slave;

   logic       pclk     = 1'b0;
   logic       preset_n = 1'b1;
   logic       psel     = 1'b0;
   logic       penable  = 1'b0;
   logic       pwrite   = 1'b0;
   logic [7:0] paddr    = 8'h00;
   logic [7:0] pwdata   = 8'h00;
   logic [7:0] prdata;
   logic       pready;
   logic       pslverr;
   logic       NMI      = 1'b0;
   logic [7:0] IRQ      = 8'h00;
   logic [7:0] Int_IRQ  = 8'h00;
   logic       i_bit    = 1'b0;
   logic       I_flag;
   logic       UI_flag;

   int total = 0;
   int bad   = 0;

   // behavioural model of the programmer-visible state
   logic       m_en;
   logic [7:0] m_mext, m_mint, m_pext, m_pint;
   logic       m_nmi;

   intr_apb_slave dut (
      .pclk     (pclk),
      .preset_n (preset_n),
      .psel     (psel),
      .penable  (penable),
      .pwrite   (pwrite),
      .paddr    (paddr),
      .pwdata   (pwdata),
      .prdata   (prdata),
      .pready   (pready),
      .pslverr  (pslverr),
      .NMI      (NMI),
      .IRQ      (IRQ),
      .Int_IRQ  (Int_IRQ),
      .i_bit    (i_bit),
      .I_flag   (I_flag),
      .UI_flag  (UI_flag)
   );

   always #5 pclk = ~pclk;

   initial begin
      #200000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // ---------------------------------------------------------------- model
   function automatic logic m_iflag();
      return m_en && !i_bit && (((m_pext & m_mext) | (m_pint & m_mint)) != 8'h00);
   endfunction

   function automatic logic [7:0] m_vec();
      if (m_nmi) return 8'h80;
      for (int i = 0; i < 8; i++) if (m_pext[i] && m_mext[i]) return 8'h10 + 8'(i);
      for (int i = 0; i < 8; i++) if (m_pint[i] && m_mint[i]) return 8'h20 + 8'(i);
      return 8'h00;
   endfunction

   function automatic logic m_err(input logic wr, input logic [7:0] a);
      return (a > 8'd6) || (wr && a == 8'd5);
   endfunction

   function automatic logic [7:0] m_read(input logic [7:0] a);
      case (a)
         8'd0:    return {7'd0, m_en};
         8'd1:    return m_mext;
         8'd2:    return m_mint;
         8'd3:    return m_pext;
         8'd4:    return m_pint;
         8'd5:    return m_vec();
         8'd6:    return {5'd0, m_nmi, m_iflag(), m_nmi};
         default: return 8'h00;
      endcase
   endfunction

   task automatic m_write(input logic [7:0] a, input logic [7:0] d);
      case (a)
         8'd0: m_en   = d[0];
         8'd1: m_mext = d;
         8'd2: m_mint = d;
         8'd3: m_pext = m_pext & ~d;
         8'd4: m_pint = m_pint & ~d;
         8'd6: if (d[0]) m_nmi = 1'b0;
         default: ;
      endcase
   endtask

   // ---------------------------------------------------------------- bus
   task automatic apb_xfer(input logic wr, input logic [7:0] a, input logic [7:0] d,
                           output logic [7:0] rd, output logic err, output int waits);
      @(posedge pclk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
      @(posedge pclk); #1;
      penable = 1'b1;
      waits = 0;
      while (pready !== 1'b1 && waits < 8) begin
         @(posedge pclk); #1;
         waits++;
      end
      rd  = prdata;
      err = pslverr;
      @(posedge pclk); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      check_val("pready_drop", 32'(pready), 32'(1'b0));
      $display("txn %s addr=0x%02h wdata=0x%02h rdata=0x%02h err=%0b waits=%0d",
               wr ? "WR" : "RD", a, d, rd, err, waits);
   endtask

   task automatic do_write(input logic [7:0] a, input logic [7:0] d);
      logic [7:0] rd; logic err; int waits; logic exp_err;
      exp_err = m_err(1'b1, a);
      apb_xfer(1'b1, a, d, rd, err, waits);
      check_val("wr_wait", 32'(waits), 32'd1);
      check_val("wr_err", 32'(err), 32'(exp_err));
      if (!exp_err) m_write(a, d);
   endtask

   task automatic do_read(input logic [7:0] a, output logic [7:0] rd);
      logic err; int waits; logic exp_err; logic [7:0] exp_d;
      exp_err = m_err(1'b0, a);
      exp_d   = exp_err ? 8'h00 : m_read(a);
      apb_xfer(1'b0, a, 8'h00, rd, err, waits);
      check_val("rd_wait", 32'(waits), 32'd1);
      check_val("rd_err", 32'(err), 32'(exp_err));
      check_val("rd_data", 32'(rd), 32'(exp_d));
   endtask

   // Change source levels; each rising bit latches its pending flag.
   task automatic set_src(input logic n, input logic [7:0] e, input logic [7:0] it);
      m_nmi  = m_nmi | (n & ~NMI);
      m_pext = m_pext | (e & ~IRQ);
      m_pint = m_pint | (it & ~Int_IRQ);
      NMI = n; IRQ = e; Int_IRQ = it;
      $display("txn SRC nmi=%0b irq=0x%02h int=0x%02h", n, e, it);
      repeat (6) @(posedge pclk);
      #1;
   endtask

   task automatic set_ibit(input logic v);
      i_bit = v;
      $display("txn IBIT i_bit=%0b", v);
      repeat (3) @(posedge pclk);
      #1;
   endtask

   task automatic check_flags(input string tag);
      repeat (2) @(posedge pclk);
      #1;
      check_val({tag, "_I"}, 32'(I_flag), 32'(m_iflag()));
      check_val({tag, "_UI"}, 32'(UI_flag), 32'(m_nmi));
   endtask

   // Reset pulse; sources held high at release are captured as one edge.
   task automatic hold_reset();
      preset_n = 1'b0;
      #1;
      check_val("rst_pready", 32'(pready), 32'd0);
      check_val("rst_pslverr", 32'(pslverr), 32'd0);
      check_val("rst_prdata", 32'(prdata), 32'd0);
      check_val("rst_I", 32'(I_flag), 32'd0);
      check_val("rst_UI", 32'(UI_flag), 32'd0);
      @(posedge pclk); #1;
      preset_n = 1'b1;
      m_en = 1'b0; m_mext = 8'h00; m_mint = 8'h00;
      m_pext = IRQ; m_pint = Int_IRQ; m_nmi = NMI;
      $display("txn RESET");
      repeat (6) @(posedge pclk);
      #1;
   endtask

   // ---------------------------------------------------------------- main
   initial begin
      logic [7:0] rd;
      logic [7:0] rd2;
      logic       err;
      int         waits;
      int         hi;

      #2;
      hold_reset();

      // basic register access
      do_write(8'h00, 8'h01);
      do_write(8'h01, 8'hFF);
      do_read(8'h01, rd);
      check_val("mask_ff", 32'(rd), 32'h000000FF);

      // decode errors
      do_read(8'h09, rd);
      check_val("err_rd0", 32'(rd), 32'd0);
      do_read(8'h05, rd);
      do_write(8'h05, 8'h55);
      do_read(8'h05, rd2);
      check_val("vec_keep", 32'(rd2), 32'(rd));

      // external IRQ[3]
      do_write(8'h01, 8'h08);
      set_ibit(1'b0);
      set_src(1'b0, 8'h08, 8'h00);
      set_src(1'b0, 8'h00, 8'h00);
      do_read(8'h03, rd);
      check_val("pend_08", 32'(rd), 32'h08);
      do_read(8'h05, rd);
      check_val("vec_13", 32'(rd), 32'h13);
      check_flags("irq3");
      check_val("irq3_lit", 32'(I_flag), 32'd1);
      do_write(8'h03, 8'h08);
      check_flags("irq3clr");

      // NMI ignores i_bit and CTRL
      set_ibit(1'b1);
      do_write(8'h00, 8'h00);
      set_src(1'b1, 8'h00, 8'h00);
      check_flags("nmi");
      do_read(8'h05, rd);
      check_val("vec_80", 32'(rd), 32'h80);
      do_write(8'h06, 8'h01);
      check_flags("nmiclr");
      set_src(1'b0, 8'h00, 8'h00);

      // set wins over W1C in the same cycle
      set_src(1'b0, 8'h00, 8'h04);
      set_src(1'b0, 8'h00, 8'h00);
      fork
         apb_xfer(1'b1, 8'h04, 8'h04, rd, err, waits);
         begin
            @(posedge pclk); #1;
            Int_IRQ = 8'h04;
         end
      join
      m_pint = (m_pint & ~8'h04) | 8'h04;
      repeat (4) @(posedge pclk);
      #1;
      do_read(8'h04, rd);
      check_val("race_bit2", 32'(rd[2]), 32'd1);
      set_src(1'b0, 8'h00, 8'h00);

      // reset in the wait state of a write to MASK_EXT
      do_write(8'h01, 8'h5A);
      @(posedge pclk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h01; pwdata = 8'hAA;
      @(posedge pclk); #1;
      penable = 1'b1;
      #2;
      hold_reset();
      hi = 0;
      repeat (4) begin
         @(posedge pclk); #1;
         if (pready) hi++;
      end
      check_val("no_resume", 32'(hi), 32'd0);
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      do_read(8'h01, rd);
      check_val("mask_rst", 32'(rd), 32'd0);

      // levels already high across reset are captured once
      set_src(1'b1, 8'h81, 8'h10);
      do_write(8'h03, 8'hFF);
      do_write(8'h04, 8'hFF);
      do_write(8'h06, 8'h01);
      hold_reset();
      do_read(8'h03, rd);
      check_val("rel_ext", 32'(rd), 32'h81);
      do_read(8'h06, rd);

      // randomized traffic
      for (int k = 0; k < 60; k++) begin
         int op;
         op = int'($urandom_range(0, 9));
         if (op <= 3) begin
            do_write(8'($urandom_range(0, 9)), 8'($urandom));
         end else if (op <= 6) begin
            do_read(8'($urandom_range(0, 9)), rd);
         end else if (op <= 8) begin
            set_src(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
         end else begin
            set_ibit(1'($urandom_range(0, 1)));
         end
         if (k % 5 == 4) check_flags("rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
